// File: rtl/fetch_pair.sv
// Dual-issue fetch stage with IF/ID pair register. A pair fetched at PCF issues
// whole, or is split so that only slot 1 issues and slot 2's word is refetched.
module fetch_pair #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic [31:0] PCF,
  input  logic [31:0] InstrF1,
  input  logic [31:0] InstrF2,
  output logic [31:0] InstrD1,
  output logic [31:0] InstrD2,
  output logic [31:0] PCD1,
  output logic [31:0] PCD2,
  output logic [31:0] PCPlus4D1,
  output logic [31:0] PCPlus4D2,
  output logic        ValidD1,
  output logic        ValidD2,
  output logic [31:0] PairCount,
  output logic [31:0] SplitCount
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  // ---------------- intra-pair hazard check ----------------
  logic [6:0] op1, op2;
  logic [4:0] rd1, rs1_2, rs2_2;
  logic       is_ctl1, wr1, raw, mem1, mem2, split;

  assign op1   = InstrF1[6:0];
  assign rd1   = InstrF1[11:7];
  assign op2   = InstrF2[6:0];
  assign rs1_2 = InstrF2[19:15];
  assign rs2_2 = InstrF2[24:20];

  always_comb begin
    is_ctl1 = (op1 == OP_BR) || (op1 == OP_JAL) || (op1 == OP_JALR);
    wr1     = (op1 == OP_R)   || (op1 == OP_I)     || (op1 == OP_LOAD) ||
              (op1 == OP_LUI) || (op1 == OP_AUIPC) || (op1 == OP_JAL)  ||
              (op1 == OP_JALR);
    // rs2 is compared even when F2 has no rs2 field; a false split only costs a cycle
    raw     = wr1 && (rd1 != 5'd0) && ((rd1 == rs1_2) || (rd1 == rs2_2));
    mem1    = (op1 == OP_LOAD) || (op1 == OP_STORE);
    mem2    = (op2 == OP_LOAD) || (op2 == OP_STORE);
    split   = is_ctl1 || raw || (mem1 && mem2);
  end

  logic unused_instr_bits;
  assign unused_instr_bits = ^{InstrF1[31:12], InstrF2[31:25], InstrF2[14:7]};

  // ---------------- PC register ----------------
  logic [31:0] pcf_q, pcf_d;

  always_comb begin
    pcf_d = pcf_q;
    if (PCSrcE)      pcf_d = PCTargetE;
    else if (StallF) pcf_d = pcf_q;
    else if (split)  pcf_d = pcf_q + 32'd4;
    else             pcf_d = pcf_q + 32'd8;
  end

  always_ff @(posedge clk) begin
    if (rst) pcf_q <= RESET_PC;
    else     pcf_q <= pcf_d;
  end

  assign PCF = pcf_q;

  // ---------------- IF/ID pair register ----------------
  logic [1:0][31:0] instr_q, pc_q, pc4_q;
  logic [1:0]       valid_q;
  logic [31:0]      pair_cnt_q, split_cnt_q;
  logic             kill, load;

  assign kill = FlushD || PCSrcE;
  assign load = !kill && !StallD;

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= {NOP_INSTR, NOP_INSTR};
      pc_q    <= '0;
      pc4_q   <= '0;
      valid_q <= 2'b00;
    end else if (kill) begin
      // PC fields are held; they mean nothing while the slot is invalid
      instr_q <= {NOP_INSTR, NOP_INSTR};
      valid_q <= 2'b00;
    end else if (load) begin
      instr_q[0] <= InstrF1;
      pc_q[0]    <= pcf_q;
      pc4_q[0]   <= pcf_q + 32'd4;
      valid_q[0] <= 1'b1;
      instr_q[1] <= split ? NOP_INSTR : InstrF2;
      pc_q[1]    <= pcf_q + 32'd4;
      pc4_q[1]   <= pcf_q + 32'd8;
      valid_q[1] <= !split;
    end
  end

  // ---------------- issue statistics (saturating) ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pair_cnt_q  <= '0;
      split_cnt_q <= '0;
    end else if (load) begin
      if (split) begin
        if (split_cnt_q != 32'hFFFF_FFFF) split_cnt_q <= split_cnt_q + 32'd1;
      end else begin
        if (pair_cnt_q != 32'hFFFF_FFFF) pair_cnt_q <= pair_cnt_q + 32'd1;
      end
    end
  end

  assign InstrD1    = instr_q[0];
  assign InstrD2    = instr_q[1];
  assign PCD1       = pc_q[0];
  assign PCD2       = pc_q[1];
  assign PCPlus4D1  = pc4_q[0];
  assign PCPlus4D2  = pc4_q[1];
  assign ValidD1    = valid_q[0];
  assign ValidD2    = valid_q[1];
  assign PairCount  = pair_cnt_q;
  assign SplitCount = split_cnt_q;

endmodule

// File: tb/tb_fetch_pair.sv
// Directed bench for fetch_pair: a behavioural pair-issue model checked every
// cycle, plus literal expectations along the directed sequence.
module tb_fetch_pair;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE, PCF, InstrF1, InstrF2;
  logic [31:0] InstrD1, InstrD2, PCD1, PCD2, PCPlus4D1, PCPlus4D2;
  logic        ValidD1, ValidD2;
  logic [31:0] PairCount, SplitCount;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_pair dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .PCF(PCF),
    .InstrF1(InstrF1), .InstrF2(InstrF2),
    .InstrD1(InstrD1), .InstrD2(InstrD2), .PCD1(PCD1), .PCD2(PCD2),
    .PCPlus4D1(PCPlus4D1), .PCPlus4D2(PCPlus4D2),
    .ValidD1(ValidD1), .ValidD2(ValidD2),
    .PairCount(PairCount), .SplitCount(SplitCount)
  );

  // Program image; everything else reads as NOP
  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h00: imem = 32'h0050_0093; // addi x1,x0,5
      32'h04: imem = 32'h0070_0113; // addi x2,x0,7
      32'h08: imem = 32'h0050_0093; // addi x1,x0,5
      32'h0C: imem = 32'h0010_81B3; // add  x3,x1,x1
      32'h10: imem = 32'h0001_8063; // beq  x3,x0,0
      32'h40: imem = 32'h0000_2283; // lw   x5,0(x0)
      32'h44: imem = 32'h0060_2223; // sw   x6,4(x0)
      default: imem = NOP;
    endcase
  endfunction

  assign InstrF1 = imem(PCF);
  assign InstrF2 = imem(PCF + 32'd4);

  // Issue rule stated over instruction classes
  function automatic bit must_split(input logic [31:0] a, input logic [31:0] b);
    logic [6:0] o1, o2;
    bit ctl, wr, dep, m1, m2;
    o1  = a[6:0];
    o2  = b[6:0];
    ctl = o1 inside {7'h63, 7'h6F, 7'h67};
    wr  = o1 inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67};
    dep = wr && a[11:7] != 0 && (a[11:7] == b[19:15] || a[11:7] == b[24:20]);
    m1  = o1 inside {7'h03, 7'h23};
    m2  = o2 inside {7'h03, 7'h23};
    return ctl || dep || (m1 && m2);
  endfunction

  logic [31:0] m_pc, m_i1, m_i2, m_p1, m_p2, m_pairs, m_splits;
  logic        m_v1, m_v2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at the edge, then one compare pass shortly after
  always @(posedge clk) begin
    logic [31:0] f1, f2;
    bit sp;
    f1 = imem(m_pc);
    f2 = imem(m_pc + 32'd4);
    sp = must_split(f1, f2);
    if (rst) begin
      m_pc = 0; m_i1 = NOP; m_i2 = NOP; m_p1 = 0; m_p2 = 0;
      m_v1 = 0; m_v2 = 0; m_pairs = 0; m_splits = 0;
    end else begin
      if (FlushD || PCSrcE) begin
        m_i1 = NOP; m_i2 = NOP; m_v1 = 0; m_v2 = 0;
      end else if (!StallD) begin
        m_i1 = f1; m_p1 = m_pc; m_v1 = 1;
        m_i2 = sp ? NOP : f2; m_p2 = m_pc + 4; m_v2 = !sp;
        if (sp) m_splits = m_splits + 1; else m_pairs = m_pairs + 1;
      end
      if (PCSrcE)      m_pc = PCTargetE;
      else if (!StallF) m_pc = m_pc + (sp ? 32'd4 : 32'd8);
    end
    #1;
    chk("model PCF", PCF, m_pc);
    chk("model InstrD1", InstrD1, m_i1);
    chk("model InstrD2", InstrD2, m_i2);
    chk("model ValidD1", {31'd0, ValidD1}, {31'd0, m_v1});
    chk("model ValidD2", {31'd0, ValidD2}, {31'd0, m_v2});
    if (m_v1) begin
      chk("model PCD1", PCD1, m_p1);
      chk("model PCPlus4D1", PCPlus4D1, m_p1 + 4);
    end
    if (m_v2) begin
      chk("model PCD2", PCD2, m_p2);
      chk("model PCPlus4D2", PCPlus4D2, m_p2 + 4);
    end
    chk("model PairCount", PairCount, m_pairs);
    chk("model SplitCount", SplitCount, m_splits);
  end

  task automatic step(input logic r, input logic sf, input logic sd, input logic fl,
                      input logic ps, input logic [31:0] tgt);
    @(negedge clk);
    rst = r; StallF = sf; StallD = sd; FlushD = fl; PCSrcE = ps; PCTargetE = tgt;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 0;
    m_pc = 0; m_i1 = NOP; m_i2 = NOP; m_p1 = 0; m_p2 = 0;
    m_v1 = 0; m_v2 = 0; m_pairs = 0; m_splits = 0;

    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 32'h1234);          // reset overrides everything
    chk("reset PCF", PCF, 32'h0);
    chk("reset ValidD1", {31'd0, ValidD1}, 32'd0);
    chk("reset InstrD2", InstrD2, NOP);
    chk("reset PairCount", PairCount, 32'd0);
    chk("reset PCPlus4D2", PCPlus4D2, 32'd0);

    step(0, 0, 0, 0, 0, 0);                  // independent pair at 0
    chk("pair PCF", PCF, 32'h8);
    chk("pair PCD2", PCD2, 32'h4);
    chk("pair InstrD2", InstrD2, 32'h0070_0113);
    chk("pair PairCount", PairCount, 32'd1);

    step(0, 0, 0, 0, 0, 0);                  // RAW split at 8
    chk("raw ValidD2", {31'd0, ValidD2}, 32'd0);
    chk("raw InstrD2", InstrD2, NOP);
    chk("raw PCF", PCF, 32'hC);

    step(0, 0, 0, 0, 0, 0);                  // add re-read as slot 1; add/beq RAW
    chk("refetch InstrD1", InstrD1, 32'h0010_81B3);
    chk("refetch SplitCount", SplitCount, 32'd2);

    step(0, 0, 0, 0, 0, 0);                  // beq at 0x10 splits
    chk("branch ValidD2", {31'd0, ValidD2}, 32'd0);
    chk("branch PCF", PCF, 32'h14);

    step(0, 0, 0, 0, 1, 32'h40);             // redirect
    chk("redirect PCF", PCF, 32'h40);
    chk("redirect ValidD1", {31'd0, ValidD1}, 32'd0);
    chk("redirect SplitCount", SplitCount, 32'd3);

    step(0, 0, 0, 0, 0, 0);                  // lw/sw share one data port
    chk("mem PCF", PCF, 32'h44);
    chk("mem InstrD1", InstrD1, 32'h0000_2283);

    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0);
    chk("stall PCF", PCF, 32'h44);
    chk("stall InstrD1", InstrD1, 32'h0000_2283);

    step(0, 1, 1, 0, 1, 32'h80);             // redirect beats stall
    chk("stall redirect PCF", PCF, 32'h80);

    step(0, 1, 0, 0, 0, 0);                  // StallF alone: same pair reloads
    step(0, 1, 0, 0, 0, 0);
    chk("stallF-only PCF", PCF, 32'h80);
    chk("stallF-only PairCount", PairCount, 32'd3);

    step(0, 0, 0, 1, 0, 0);                  // flush
    chk("flush ValidD2", {31'd0, ValidD2}, 32'd0);
    chk("flush PCF", PCF, 32'h88);

    step(0, 0, 0, 0, 1, 32'hFFFF_FFF8);
    step(0, 0, 0, 0, 0, 0);                  // wrap
    chk("wrap PCF", PCF, 32'h0);
    chk("wrap PCD2", PCD2, 32'hFFFF_FFFC);

    step(0, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 1, 32'h200);            // reset mid-stall/redirect
    chk("rst-mid PCF", PCF, 32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("post-rst PCF", PCF, 32'h8);
    step(0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
